// File: rtl/traffic_light_pkg.sv
// Shared types and constants for the traffic light controller and its phase timer.
package traffic_light_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10
  } state_t;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

endpackage

// File: rtl/traffic_light_timer.sv
// Phase down-counter: loads on request, otherwise counts down to zero and holds there.
module traffic_timer
  import traffic_light_pkg::*;
#(
  parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/traffic_light.sv
// Fixed-cycle RED -> GREEN -> YELLOW traffic light with Moore lamp decode.
module traffic_light
  import traffic_light_pkg::*;
#(
  parameter int RED_TIME    = 5,
  parameter int GREEN_TIME  = 5,
  parameter int YELLOW_TIME = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] lights
);

  localparam logic [CNT_W-1:0] RED_LOAD    = CNT_W'(RED_TIME - 1);
  localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TIME - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TIME - 1);

  state_t           state_q;
  state_t           state_d;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             zero;

  traffic_timer #(
    .RESET_VAL(RED_LOAD)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  // The next phase's duration is loaded on the same edge that leaves the current one.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = RED_LOAD;
    case (state_q)
      RED: begin
        if (zero) begin
          state_d  = GREEN;
          load     = 1'b1;
          load_val = GREEN_LOAD;
        end
      end
      GREEN: begin
        if (zero) begin
          state_d  = YELLOW;
          load     = 1'b1;
          load_val = YELLOW_LOAD;
        end
      end
      YELLOW: begin
        if (zero) begin
          state_d  = RED;
          load     = 1'b1;
          load_val = RED_LOAD;
        end
      end
      default: begin
        state_d  = RED;
        load     = 1'b1;
        load_val = RED_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    lights = LIGHT_RED;
    case (state_q)
      RED:     lights = LIGHT_RED;
      GREEN:   lights = LIGHT_GREEN;
      YELLOW:  lights = LIGHT_YELLOW;
      default: lights = LIGHT_RED;
    endcase
  end

endmodule

// File: tb/tb_traffic_light.sv
// Self-checking bench: three parameterisations compared against a cycle-position model.
module tb_traffic_light;
  import traffic_light_pkg::*;

  logic       clk;
  logic       rst;
  logic [2:0] lights0;
  logic [2:0] lights1;
  logic [2:0] lights2;

  int total;
  int bad;
  int kc[3];
  int rt[3] = '{5, 1, 5};
  int gt[3] = '{5, 1, 255};
  int yt[3] = '{2, 1, 2};

  traffic_light u_def (
    .clk    (clk),
    .rst    (rst),
    .lights (lights0)
  );

  traffic_light #(
    .RED_TIME(1), .GREEN_TIME(1), .YELLOW_TIME(1)
  ) u_ones (
    .clk    (clk),
    .rst    (rst),
    .lights (lights1)
  );

  traffic_light #(
    .GREEN_TIME(255)
  ) u_long (
    .clk    (clk),
    .rst    (rst),
    .lights (lights2)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Reference: k rising edges after release, position within the repeating period picks the lamp.
  function automatic logic [2:0] model_light(int k, int r, int g, int y);
    int p;
    p = k % (r + g + y);
    if (p < r) return 3'b100;
    else if (p < r + g) return 3'b001;
    else return 3'b010;
  endfunction

  function automatic logic [2:0] lamp(int d);
    if (d == 0) return lights0;
    else if (d == 1) return lights1;
    else return lights2;
  endfunction

  task automatic advance();
    @(negedge clk);
    for (int d = 0; d < 3; d++) kc[d]++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    for (int d = 0; d < 3; d++) begin
      total++;
      if (lamp(d) !== 3'b100) begin
        bad++;
        $display("[TB] FAIL reset_hold dut%0d got=%b want=100", d, lamp(d));
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int d = 0; d < 3; d++) kc[d] = 0;
    #1;
    for (int d = 0; d < 3; d++) begin
      total++;
      if (lamp(d) !== 3'b100) begin
        bad++;
        $display("[TB] FAIL release dut%0d got=%b want=100", d, lamp(d));
      end
    end
    for (int c = 0; c < 13; c++) begin
      advance();
      for (int d = 0; d < 3; d++) begin
        total++;
        if (lamp(d) !== model_light(kc[d], rt[d], gt[d], yt[d])) begin
          bad++;
          $display("[TB] FAIL first_cycle dut%0d k=%0d got=%b want=%b", d, kc[d], lamp(d),
                   model_light(kc[d], rt[d], gt[d], yt[d]));
        end
      end
    end
  endtask

  task automatic test_period();
    for (int c = 0; c < 20; c++) begin
      advance();
      for (int d = 0; d < 3; d++) begin
        total++;
        if (lamp(d) !== model_light(kc[d], rt[d], gt[d], yt[d])) begin
          bad++;
          $display("[TB] FAIL period dut%0d k=%0d got=%b want=%b", d, kc[d], lamp(d),
                   model_light(kc[d], rt[d], gt[d], yt[d]));
        end
        total++;
        if ($countones(lamp(d)) != 1) begin
          bad++;
          $display("[TB] FAIL onehot dut%0d got=%b want=one bit", d, lamp(d));
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int target;
    int hold;
    int guard;
    target = 5 + $urandom_range(0, 4);
    guard = 0;
    while ((kc[0] % 12) != target && guard < 30) begin
      advance();
      guard++;
    end
    total++;
    if (model_light(kc[0], 5, 5, 2) !== 3'b001 || lights0 !== 3'b001) begin
      bad++;
      $display("[TB] FAIL mid_green_reach got=%b want=001", lights0);
    end
    #3;
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      total++;
      if (lamp(d) !== 3'b100) begin
        bad++;
        $display("[TB] FAIL async_reset dut%0d got=%b want=100", d, lamp(d));
      end
    end
    hold = $urandom_range(1, 3);
    for (int c = 0; c < hold; c++) begin
      advance();
      total++;
      if (lights0 !== 3'b100) begin
        bad++;
        $display("[TB] FAIL in_reset got=%b want=100", lights0);
      end
    end
    #2;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) kc[d] = 0;
    for (int c = 0; c < 26; c++) begin
      advance();
      for (int d = 0; d < 3; d++) begin
        total++;
        if (lamp(d) !== model_light(kc[d], rt[d], gt[d], yt[d])) begin
          bad++;
          $display("[TB] FAIL after_reset dut%0d k=%0d got=%b want=%b", d, kc[d], lamp(d),
                   model_light(kc[d], rt[d], gt[d], yt[d]));
        end
      end
    end
  endtask

  task automatic test_all_ones();
    logic [2:0] seq[3];
    seq[0] = 3'b100;
    seq[1] = 3'b001;
    seq[2] = 3'b010;
    for (int c = 0; c < 9; c++) begin
      advance();
      total++;
      if (lights1 !== seq[kc[1] % 3]) begin
        bad++;
        $display("[TB] FAIL all_ones k=%0d got=%b want=%b", kc[1], lights1, seq[kc[1] % 3]);
      end
    end
  endtask

  task automatic test_long_green();
    int green_run;
    int max_run;
    green_run = 0;
    max_run = 0;
    for (int c = 0; c < 290; c++) begin
      advance();
      total++;
      if (lights2 !== model_light(kc[2], 5, 255, 2)) begin
        bad++;
        $display("[TB] FAIL long_green k=%0d got=%b want=%b", kc[2], lights2,
                 model_light(kc[2], 5, 255, 2));
      end
      if (lights2 === 3'b001) green_run++;
      else green_run = 0;
      if (green_run > max_run) max_run = green_run;
    end
    total++;
    if (max_run > 255) begin
      bad++;
      $display("[TB] FAIL green_length got=%0d want<=255", max_run);
    end
  endtask

  task automatic test_illegal();
    int pre;
    pre = $urandom_range(1, 30);
    for (int c = 0; c < pre; c++) advance();
    force u_def.state_q = state_t'(2'b11);
    #1;
    release u_def.state_q;
    #1;
    total++;
    if (lights0 !== 3'b100) begin
      bad++;
      $display("[TB] FAIL illegal_decode got=%b want=100", lights0);
    end
    advance();
    kc[0] = 0;
    for (int c = 0; c < 25; c++) begin
      total++;
      if (lights0 !== model_light(kc[0], 5, 5, 2)) begin
        bad++;
        $display("[TB] FAIL illegal_recover k=%0d got=%b want=%b", kc[0], lights0,
                 model_light(kc[0], 5, 5, 2));
      end
      advance();
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_period();
    test_mid_reset();
    test_all_ones();
    test_long_green();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
